// File: rtl/seq_divider_qr.sv
// Restoring divider (WIDTH, SIGNED): one quotient bit per clock, result WIDTH+1 clocks after accept (1 for divide-by-zero).
// Result held under quotient_ready backpressure; no new accept until handoff. Define DIVIDER_EARLY_OUT_EN for 1-clock |dividend|<|divisor| results.
module seq_divider_qr #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] dividend_data,
  input  logic             dividend_valid,
  output logic             dividend_ready,
  input  logic [WIDTH-1:0] divisor_data,
  input  logic             divisor_valid,
  output logic             divisor_ready,
  output logic [WIDTH-1:0] quotient_data,
  output logic [WIDTH-1:0] remainder_data,
  output logic             div_by_zero,
  output logic             quotient_valid,
  input  logic             quotient_ready
);

  localparam int CW  = $clog2(WIDTH);
  localparam bit SGN = (SIGNED != 0);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] quo_out_q;
  logic [WIDTH-1:0] rem_out_q;
  logic             dbz_q;
  logic             vld_q;

  logic             accept;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   rem_shift;
  logic             ge;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return (SGN && x[WIDTH-1]) ? -x : x;
  endfunction

  assign accept         = (state_q == IDLE) && dividend_valid && divisor_valid;
  assign dividend_ready = accept;
  assign divisor_ready  = accept;
  assign dvd_mag        = magnitude(dividend_data);
  assign dvs_mag        = magnitude(divisor_data);

  // dvd_q shifts dividend bits out of the MSB while quotient bits enter at the LSB.
  always_comb begin
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    ge        = rem_shift >= {1'b0, dvs_q};
    rem_d     = ge ? (rem_shift[WIDTH-1:0] - dvs_q) : rem_shift[WIDTH-1:0];
    dvd_d     = {dvd_q[WIDTH-2:0], ge};
    q_fin     = neg_quo_q ? -dvd_d : dvd_d;
    r_fin     = neg_rem_q ? -rem_d : rem_d;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            dvd_q     <= dvd_mag;
            dvs_q     <= dvs_mag;
            rem_q     <= '0;
            cnt_q     <= CW'(WIDTH - 1);
            neg_quo_q <= SGN && (dividend_data[WIDTH-1] ^ divisor_data[WIDTH-1]);
            neg_rem_q <= SGN && dividend_data[WIDTH-1];
            if (divisor_data == '0) begin
              quo_out_q <= '1;
              rem_out_q <= dividend_data;
              dbz_q     <= 1'b1;
              vld_q     <= 1'b1;
              state_q   <= DONE;
            end
`ifdef DIVIDER_EARLY_OUT_EN
            else if (dvd_mag < dvs_mag) begin
              quo_out_q <= '0;
              rem_out_q <= dividend_data;
              dbz_q     <= 1'b0;
              vld_q     <= 1'b1;
              state_q   <= DONE;
            end
`endif
            else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            quo_out_q <= q_fin;
            rem_out_q <= r_fin;
            dbz_q     <= 1'b0;
            vld_q     <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (quotient_ready) begin
            vld_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient_data  = quo_out_q;
  assign remainder_data = rem_out_q;
  assign div_by_zero    = dbz_q;
  assign quotient_valid = vld_q;

endmodule

// File: tb/tb_seq_divider_qr.sv
// Bench for seq_divider_qr: directed table, handshake corner sequences and random pairs vs an arithmetic model.
// Instances: 0 = 8-bit unsigned, 1 = 8-bit signed, 2 = 16-bit unsigned, 3 = 16-bit signed.
module tb_seq_divider_qr;

  logic clk  = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] a_dat [4];
  logic [15:0] b_dat [4];
  logic [3:0]  a_vld, b_vld, q_rdy;
  logic [3:0]  a_rdy, b_rdy, q_vld, dz;
  logic [7:0]  q0, r0, q1, r1;
  logic [15:0] q2, r2, q3, r3;

  int n_vec = 0;
  int n_bad = 0;

`ifdef DIVIDER_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 9;
`endif

  seq_divider_qr #(.WIDTH(8), .SIGNED(0)) u_u8 (
    .clk(clk), .arst(arst),
    .dividend_data(a_dat[0][7:0]), .dividend_valid(a_vld[0]), .dividend_ready(a_rdy[0]),
    .divisor_data(b_dat[0][7:0]), .divisor_valid(b_vld[0]), .divisor_ready(b_rdy[0]),
    .quotient_data(q0), .remainder_data(r0), .div_by_zero(dz[0]),
    .quotient_valid(q_vld[0]), .quotient_ready(q_rdy[0]));

  seq_divider_qr #(.WIDTH(8), .SIGNED(1)) u_s8 (
    .clk(clk), .arst(arst),
    .dividend_data(a_dat[1][7:0]), .dividend_valid(a_vld[1]), .dividend_ready(a_rdy[1]),
    .divisor_data(b_dat[1][7:0]), .divisor_valid(b_vld[1]), .divisor_ready(b_rdy[1]),
    .quotient_data(q1), .remainder_data(r1), .div_by_zero(dz[1]),
    .quotient_valid(q_vld[1]), .quotient_ready(q_rdy[1]));

  seq_divider_qr #(.WIDTH(16), .SIGNED(0)) u_u16 (
    .clk(clk), .arst(arst),
    .dividend_data(a_dat[2]), .dividend_valid(a_vld[2]), .dividend_ready(a_rdy[2]),
    .divisor_data(b_dat[2]), .divisor_valid(b_vld[2]), .divisor_ready(b_rdy[2]),
    .quotient_data(q2), .remainder_data(r2), .div_by_zero(dz[2]),
    .quotient_valid(q_vld[2]), .quotient_ready(q_rdy[2]));

  seq_divider_qr #(.WIDTH(16), .SIGNED(1)) u_s16 (
    .clk(clk), .arst(arst),
    .dividend_data(a_dat[3]), .dividend_valid(a_vld[3]), .dividend_ready(a_rdy[3]),
    .divisor_data(b_dat[3]), .divisor_valid(b_vld[3]), .divisor_ready(b_rdy[3]),
    .quotient_data(q3), .remainder_data(r3), .div_by_zero(dz[3]),
    .quotient_valid(q_vld[3]), .quotient_ready(q_rdy[3]));

  typedef struct {
    int          k;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    int          lat;
  } vec_t;

  function automatic logic [15:0] wmask(input int k);
    return (k < 2) ? 16'h00FF : 16'hFFFF;
  endfunction

  function automatic logic [15:0] get_q(input int k);
    case (k)
      0:       return {8'h00, q0};
      1:       return {8'h00, q1};
      2:       return q2;
      default: return q3;
    endcase
  endfunction

  function automatic logic [15:0] get_r(input int k);
    case (k)
      0:       return {8'h00, r0};
      1:       return {8'h00, r1};
      2:       return r2;
      default: return r3;
    endcase
  endfunction

  // Reference: plain integer division (truncates toward zero, remainder follows dividend sign).
  task automatic model(input int k, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r, output logic z, output int lat);
    logic [15:0] m;
    longint      ai, bi, qi, ri, aa, ba;
    int          w;
    m = wmask(k);
    w = (k < 2) ? 8 : 16;
    if (k % 2 == 1) begin
      ai = (w == 8) ? longint'($signed(a[7:0])) : longint'($signed(a));
      bi = (w == 8) ? longint'($signed(b[7:0])) : longint'($signed(b));
    end else begin
      ai = longint'(a & m);
      bi = longint'(b & m);
    end
    if (bi == 0) begin
      q = m; r = a & m; z = 1'b1; lat = 1;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      q = qi[15:0] & m;
      r = ri[15:0] & m;
      z = 1'b0;
      lat = w + 1;
      aa = (ai < 0) ? -ai : ai;
      ba = (bi < 0) ? -bi : bi;
`ifdef DIVIDER_EARLY_OUT_EN
      if (aa < ba) lat = 1;
`else
      if (aa < ba) lat = w + 1;
`endif
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: no response within cycle budget", name);
  endtask

  task automatic wait_result(input int k, output int lat);
    lat = 1;
    while (!q_vld[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!q_vld[k]) timeout("result_wait");
  endtask

  // One full transaction; lat counts clocks from the acceptance edge to quotient_valid.
  task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] b, input int hold,
                       output logic [15:0] q, output logic [15:0] r, output logic z, output int lat);
    int n;
    @(negedge clk);
    a_dat[k] = a; b_dat[k] = b; a_vld[k] = 1'b1; b_vld[k] = 1'b1; q_rdy[k] = 1'b0;
    #1;
    n = 0;
    while (!a_rdy[k] && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (!a_rdy[k]) timeout("accept_wait");
    @(posedge clk); #1;
    a_vld[k] = 1'b0; b_vld[k] = 1'b0;
    wait_result(k, lat);
    q = get_q(k); r = get_r(k); z = dz[k];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, q_vld[k]}, 32'd1);
      chk("hold_quotient", {16'd0, get_q(k)}, {16'd0, q});
      chk("hold_remainder", {16'd0, get_r(k)}, {16'd0, r});
    end
    q_rdy[k] = 1'b1;
    @(posedge clk); #1;
    q_rdy[k] = 1'b0;
    chk("handoff_valid_low", {31'd0, q_vld[k]}, 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [14];
    logic [15:0] gq, gr, eq, er, a, b;
    logic        gz, ez;
    int          glat, elat, k, sel;

    tbl[0]  = '{0, 16'd200,   16'd7,     16'd28,    16'd4,    1'b0, 9};
    tbl[1]  = '{0, 16'd55,    16'd0,     16'h00FF,  16'd55,   1'b1, 1};
    tbl[2]  = '{1, 16'h00F9,  16'h0002,  16'h00FD,  16'h00FF, 1'b0, 9};
    tbl[3]  = '{1, 16'h0007,  16'h00FE,  16'h00FD,  16'h0001, 1'b0, 9};
    tbl[4]  = '{1, 16'h00F9,  16'h00FE,  16'h0003,  16'h00FF, 1'b0, 9};
    tbl[5]  = '{1, 16'h0080,  16'h00FF,  16'h0080,  16'h0000, 1'b0, 9};
    tbl[6]  = '{1, 16'h0005,  16'h0000,  16'h00FF,  16'h0005, 1'b1, 1};
    tbl[7]  = '{0, 16'd255,   16'd1,     16'd255,   16'd0,    1'b0, 9};
    tbl[8]  = '{0, 16'd3,     16'd9,     16'd0,     16'd3,    1'b0, EO_LAT};
    tbl[9]  = '{1, 16'h00FF,  16'h0005,  16'h0000,  16'h00FF, 1'b0, EO_LAT};
    tbl[10] = '{2, 16'hFFFF,  16'd255,   16'h0101,  16'd0,    1'b0, 17};
    tbl[11] = '{3, 16'h8000,  16'hFFFF,  16'h8000,  16'h0000, 1'b0, 17};
    tbl[12] = '{3, 16'd1000,  16'hFFF9,  16'hFF72,  16'd6,    1'b0, 17};
    tbl[13] = '{2, 16'd1234,  16'd0,     16'hFFFF,  16'd1234, 1'b1, 1};

    for (int i = 0; i < 4; i++) begin
      a_dat[i] = '0; b_dat[i] = '0;
    end
    a_vld = '0; b_vld = '0; q_rdy = '0;

    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("reset_valid", {31'd0, q_vld[i]}, 32'd0);
      chk("reset_quotient", {16'd0, get_q(i)}, 32'd0);
      chk("reset_remainder", {16'd0, get_r(i)}, 32'd0);
      chk("reset_dbz", {31'd0, dz[i]}, 32'd0);
    end
    arst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      do_op(tbl[i].k, tbl[i].a, tbl[i].b, i % 3, gq, gr, gz, glat);
      chk("table_quotient", {16'd0, gq}, {16'd0, tbl[i].q});
      chk("table_remainder", {16'd0, gr}, {16'd0, tbl[i].r});
      chk("table_dbz", {31'd0, gz}, {31'd0, tbl[i].z});
      chk("table_latency", glat, tbl[i].lat);
    end

    // Lone dividend must never be consumed.
    @(negedge clk);
    a_dat[0] = 16'd200; b_dat[0] = 16'd3; a_vld[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("lone_dividend_ready", {31'd0, a_rdy[0]}, 32'd0);
      chk("lone_divisor_ready", {31'd0, b_rdy[0]}, 32'd0);
      @(negedge clk);
    end

    // Reset in the middle of a calculation drops the result.
    b_vld[0] = 1'b1;
    #1;
    chk("pair_accept", {31'd0, a_rdy[0]}, 32'd1);
    @(posedge clk); #1;
    a_vld[0] = 1'b0; b_vld[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); arst = 1'b1;
    @(negedge clk); arst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("aborted_valid", {31'd0, q_vld[0]}, 32'd0);
    end
    do_op(0, 16'd100, 16'd10, 0, gq, gr, gz, glat);
    chk("post_reset_quotient", {16'd0, gq}, 32'd10);
    chk("post_reset_remainder", {16'd0, gr}, 32'd0);
    chk("post_reset_latency", glat, 32'd9);

    // Backpressure with a new pair waiting; it is taken only after the handoff.
    @(negedge clk);
    a_dat[0] = 16'd20; b_dat[0] = 16'd6; a_vld[0] = 1'b1; b_vld[0] = 1'b1;
    #1;
    chk("bp_accept", {31'd0, a_rdy[0]}, 32'd1);
    @(posedge clk); #1;
    a_vld[0] = 1'b0; b_vld[0] = 1'b0;
    wait_result(0, glat);
    chk("bp_latency", glat, 32'd9);
    a_dat[0] = 16'd9; b_dat[0] = 16'd4; a_vld[0] = 1'b1; b_vld[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, q_vld[0]}, 32'd1);
      chk("bp_quotient", {16'd0, get_q(0)}, 32'd3);
      chk("bp_remainder", {16'd0, get_r(0)}, 32'd2);
      chk("bp_no_dividend_ready", {31'd0, a_rdy[0]}, 32'd0);
      chk("bp_no_divisor_ready", {31'd0, b_rdy[0]}, 32'd0);
    end
    q_rdy[0] = 1'b1;
    #1;
    chk("bp_handoff_no_accept", {31'd0, a_rdy[0]}, 32'd0);
    @(posedge clk); #1;
    q_rdy[0] = 1'b0;
    chk("bp_valid_dropped", {31'd0, q_vld[0]}, 32'd0);
    chk("bp_next_accept", {31'd0, a_rdy[0]}, 32'd1);
    @(posedge clk); #1;
    a_vld[0] = 1'b0; b_vld[0] = 1'b0;
    wait_result(0, glat);
    chk("bp_next_quotient", {16'd0, get_q(0)}, 32'd2);
    chk("bp_next_remainder", {16'd0, get_r(0)}, 32'd1);
    chk("bp_next_latency", glat, 32'd9);
    q_rdy[0] = 1'b1;
    @(posedge clk); #1;
    q_rdy[0] = 1'b0;

    // Random pairs on every instance, weighted toward zero, small and overflow divisors.
    for (int i = 0; i < 1400; i++) begin
      k = (i < 400) ? (i % 2) : (2 + (i % 2));
      a = 16'($urandom) & wmask(k);
      b = 16'($urandom) & wmask(k);
      sel = $urandom_range(0, 15);
      if (sel == 0) b = 16'd0;
      else if (sel < 4) b = 16'($urandom_range(1, 5));
      else if (sel == 4) begin
        a = (k < 2) ? 16'h0080 : 16'h8000;
        b = wmask(k);
      end else if (sel == 5) b = (-16'($urandom_range(1, 5))) & wmask(k);
      model(k, a, b, eq, er, ez, elat);
      do_op(k, a, b, $urandom_range(0, 2), gq, gr, gz, glat);
      chk("rand_quotient", {16'd0, gq}, {16'd0, eq});
      chk("rand_remainder", {16'd0, gr}, {16'd0, er});
      chk("rand_dbz", {31'd0, gz}, {31'd0, ez});
      chk("rand_latency", glat, elat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_divider_qr.md
Name: seq_divider_qr

Overview:
Parametrised sequential restoring divider, successor to the fixed 8-bit unsigned divider.
- Generalised to WIDTH bits, with optional signed mode.
- Adds remainder output, divide-by-zero flag and stall-safe output handshake.
- Sits between two valid/ready operand producers and one result consumer; computes one quotient bit per clock.

Parameters:
WIDTH, 8, operand/result bit width (>=2)
SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands and results

Ports:
clk  in  1  rising-edge clock
arst  in  1  asynchronous reset, active-high
dividend_data  in  WIDTH  dividend operand
dividend_valid  in  1  dividend present
dividend_ready  out  1  dividend consumed this cycle
divisor_data  in  WIDTH  divisor operand
divisor_valid  in  1  divisor present
divisor_ready  out  1  divisor consumed this cycle
quotient_data  out  WIDTH  quotient
remainder_data  out  WIDTH  remainder
div_by_zero  out  1  result came from divisor==0
quotient_valid  out  1  result present
quotient_ready  in  1  consumer accepts result

Behaviour:
- One clock (clk); reset arst is asynchronous, active-high.
- Reset: state=IDLE; quotient_valid=0, quotient_data=0, remainder_data=0, div_by_zero=0, all internal registers 0. arst mid-CALC or mid-DONE aborts the operation; the result is lost and quotient_valid is never raised for it.
- States: IDLE, CALC, DONE.
- IDLE:
  - dividend_ready = divisor_ready = dividend_valid & divisor_valid. Both operands are consumed together; a lone valid is never consumed.
  - On that acceptance edge, latch operands (magnitudes if SIGNED), bit counter = WIDTH-1, partial remainder = 0.
  - Divisor==0: go to DONE. Otherwise go to CALC.
- CALC:
  - One iteration per clock, MSB first: shift the next dividend bit into the partial remainder (WIDTH+1 bits internally, no overflow).
  - If partial remainder >= divisor: subtract divisor and set the quotient bit.
  - After the bit-0 iteration, go to DONE.
  - Ready outputs are 0 in CALC and DONE.
- DONE:
  - quotient_valid=1; quotient_data, remainder_data and div_by_zero are held stable while quotient_valid & !quotient_ready.
  - quotient_valid & quotient_ready → IDLE, quotient_valid=0 next cycle. Data outputs keep their last value.
- Latency and throughput:
  - Nonzero divisor: quotient_valid rises WIDTH+1 clocks after the acceptance edge.
  - Divisor==0: quotient_valid rises 1 clock after the acceptance edge.
  - Best case: one operation per WIDTH+2 clocks. There is no acceptance in the same cycle as result handoff.
- Divide by zero: quotient = all ones (unsigned) or -1 (signed); remainder = dividend as presented; div_by_zero=1. div_by_zero=0 for all other results.
- SIGNED=1 sign rules:
  - Quotient is negated when the operand signs differ; truncation toward zero.
  - Remainder takes the dividend's sign, and |remainder| < |divisor|.
  - Most-negative / -1: quotient = most-negative value (wraps), remainder = 0, div_by_zero=0.
- Invariant for every non-zero-divisor case: dividend == quotient*divisor + remainder, modulo 2^WIDTH.

Optional Feature:
DIVIDER_EARLY_OUT_EN
- Defined: at acceptance, if divisor!=0 and |dividend| < |divisor|, go directly to DONE with quotient=0 and remainder=dividend (signed value retained); latency 1 clock.
- Undefined: such operands take the full CALC path; results are bit-identical, latency WIDTH+1.

Test Plan:
- WIDTH=8, SIGNED=0: 200/7 → quotient 28, remainder 4, div_by_zero=0, quotient_valid 9 clocks after acceptance.
- WIDTH=8: 55/0 → quotient 0xFF, remainder 55, div_by_zero=1, quotient_valid 1 clock after acceptance.
- WIDTH=8, SIGNED=1, four sign combinations:
  - -7/2 → quotient -3, remainder -1
  - 7/-2 → quotient -3, remainder 1
  - -7/-2 → quotient 3, remainder -1
  - -128/-1 → quotient -128, remainder 0
- Backpressure: hold quotient_ready=0 for 5 clocks after quotient_valid; outputs stable, no ready asserted. Present a new operand pair at the same time; it is accepted only after the handoff cycle.
- Handshake edges: dividend_valid alone for 10 clocks → no ready asserted. Then assert arst during CALC → quotient_valid stays 0 and the next 100/10 gives quotient 10, remainder 0.
- WIDTH=16, 1000 random pairs against the reference model. With DIVIDER_EARLY_OUT_EN: 3/9 → quotient 0, remainder 3, latency 1 clock.
